// File: rtl/lsu_sram_mmio.sv
// Load/store unit: RV32 byte/half/word accesses to a 16-bit async SRAM plus
// byte-addressed memory-mapped LED/HEX/LCD outputs and synchronised switch/button inputs.
module lsu_sram_mmio #(
    parameter int DMEM_AW  = 13,
    parameter int SRAM_AW  = 18,
    parameter int WAIT_CYC = 1,
    parameter int N_HEX    = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_req,
    input  logic               i_wren,
    input  logic [2:0]         i_func3,
    input  logic [31:0]        i_addr,
    input  logic [31:0]        i_st_data,
    output logic [31:0]        o_ld_data,
    output logic               o_ack,
    output logic               o_fault,
    input  logic [31:0]        i_io_sw,
    input  logic [3:0]         i_io_btn,
    output logic [31:0]        o_io_ledr,
    output logic [31:0]        o_io_ledg,
    output logic [7*N_HEX-1:0] o_io_hex,
    output logic [31:0]        o_io_lcd,
    output logic [SRAM_AW-1:0] o_sram_addr,
    inout  wire  [15:0]        io_sram_dq,
    output logic               o_sram_ce_n,
    output logic               o_sram_we_n,
    output logic               o_sram_oe_n,
    output logic               o_sram_lb_n,
    output logic               o_sram_ub_n
);

    localparam int              WW        = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [WW-1:0]   WAIT_LAST = WW'(WAIT_CYC - 1);
    localparam logic [16:0]     DMEM_BASE = 17'h02000;
    localparam logic [16:0]     DMEM_END  = DMEM_BASE + 17'(2**DMEM_AW);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_LO, S_HI, S_DONE} state_t;

    state_t             state, next_state;
    logic [15:0]        addr_q;
    logic [2:0]         func3_q;
    logic               wren_q;
    logic [31:0]        st_q;
    logic               fault_q;
    logic [15:0]        lo_q;
    logic [WW-1:0]      wait_cnt;
    logic [31:0]        ld_q;
    logic [63:0][7:0]   out_mem;
    logic [31:0]        sw_s1, sw_s2;
    logic [3:0]         btn_s1, btn_s2;
    logic [15:0]        dq_out;
    logic               dq_oe;
    logic               unused_addr_hi;

    logic       in_dmem, is_out, is_in, bad_access, byte_acc, wait_last;
    logic [1:0] size;
    logic [3:0] byte_en;
    logic [31:0] io_raw, sram_raw;

    function automatic logic [31:0] extend_load(input logic [31:0] raw, input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   extend_load = f3[2] ? {24'h0, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
            2'b01:   extend_load = f3[2] ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: extend_load = raw;
        endcase
    endfunction

    // Only switch bytes 0-3 and the button nibble at offset 0x10 are populated.
    function automatic logic [7:0] in_byte(input logic [4:0] ib, input logic [31:0] sw,
                                           input logic [3:0] btn);
        if (ib[4:2] == 3'b000)
            in_byte = sw[8*ib[1:0] +: 8];
        else if (ib == 5'h10)
            in_byte = {4'h0, btn};
        else
            in_byte = 8'h00;
    endfunction

    assign unused_addr_hi = ^i_addr[31:16];

    assign size      = func3_q[1:0];
    assign byte_acc  = (size == 2'b00);
    assign in_dmem   = ({1'b0, addr_q} >= DMEM_BASE) && ({1'b0, addr_q} < DMEM_END);
    assign is_out    = (addr_q[15:6] == 10'h1C0);
    assign is_in     = (addr_q[15:5] == 11'h3C0);
    assign wait_last = (wait_cnt == WAIT_LAST);
    assign bad_access = (size == 2'b11) || (func3_q == 3'b110) || (func3_q == 3'b111) ||
                        ((size == 2'b01) && addr_q[0]) ||
                        ((size == 2'b10) && (addr_q[1:0] != 2'b00));
    assign byte_en   = (size == 2'b00) ? 4'b0001 : (size == 2'b01) ? 4'b0011 : 4'b1111;
    assign sram_raw  = (byte_acc && addr_q[0]) ? {24'h0, io_sram_dq[15:8]} : {16'h0, io_sram_dq};

    always_comb begin
        io_raw = '0;
        for (int k = 0; k < 4; k++) begin
            if (is_out)
                io_raw[8*k +: 8] = out_mem[addr_q[5:0] + 6'(k)];
            else if (is_in)
                io_raw[8*k +: 8] = in_byte(addr_q[4:0] + 5'(k), sw_s2, btn_s2);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sw_s1  <= '0;
            sw_s2  <= '0;
            btn_s1 <= '0;
            btn_s2 <= '0;
        end else begin
            sw_s1  <= i_io_sw;
            sw_s2  <= sw_s1;
            btn_s1 <= i_io_btn;
            btn_s2 <= btn_s1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state  = state;
        o_ack       = 1'b0;
        o_fault     = 1'b0;
        o_sram_ce_n = 1'b1;
        o_sram_we_n = 1'b1;
        o_sram_oe_n = 1'b1;
        o_sram_lb_n = 1'b1;
        o_sram_ub_n = 1'b1;
        dq_oe       = 1'b0;
        dq_out      = st_q[15:0];
        o_sram_addr = SRAM_AW'(addr_q[DMEM_AW-1:1]);
        case (state)
            S_IDLE:  if (i_req) next_state = S_CHECK;
            S_CHECK: next_state = (bad_access || !in_dmem) ? S_DONE : S_LO;
            S_LO:    if (wait_last) next_state = (size == 2'b10) ? S_HI : S_DONE;
            S_HI:    if (wait_last) next_state = S_DONE;
            S_DONE: begin
                o_ack      = 1'b1;
                o_fault    = fault_q;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
        // A high byte travels on the upper lane, so it is shifted up to dq[15:8].
        if (state == S_LO || state == S_HI) begin
            o_sram_ce_n = 1'b0;
            o_sram_we_n = !wren_q;
            o_sram_oe_n = wren_q;
            o_sram_lb_n = byte_acc && addr_q[0];
            o_sram_ub_n = byte_acc && !addr_q[0];
            dq_oe       = wren_q;
            if (state == S_HI) begin
                dq_out      = st_q[31:16];
                o_sram_addr = SRAM_AW'(addr_q[DMEM_AW-1:1]) + SRAM_AW'(1);
            end else if (byte_acc) begin
                dq_out = addr_q[0] ? {st_q[7:0], 8'h00} : {8'h00, st_q[7:0]};
            end
        end
    end

    assign io_sram_dq = dq_oe ? dq_out : 16'hzzzz;
    assign o_ld_data  = ld_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr_q   <= '0;
            func3_q  <= '0;
            wren_q   <= 1'b0;
            st_q     <= '0;
            fault_q  <= 1'b0;
            lo_q     <= '0;
            wait_cnt <= '0;
            ld_q     <= '0;
        end else begin
            wait_cnt <= '0;
            case (state)
                S_IDLE: if (i_req) begin
                    addr_q  <= i_addr[15:0];
                    func3_q <= i_func3;
                    wren_q  <= i_wren;
                    st_q    <= i_st_data;
                    fault_q <= 1'b0;
                end
                S_CHECK: begin
                    fault_q <= bad_access;
                    if (bad_access || !in_dmem)
                        ld_q <= (bad_access || wren_q) ? '0 : extend_load(io_raw, func3_q);
                end
                S_LO: begin
                    if (!wait_last) begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end else begin
                        lo_q <= io_sram_dq;
                        if (size != 2'b10)
                            ld_q <= wren_q ? '0 : extend_load(sram_raw, func3_q);
                    end
                end
                S_HI: begin
                    if (!wait_last)
                        wait_cnt <= wait_cnt + WW'(1);
                    else
                        ld_q <= wren_q ? '0 : {io_sram_dq, lo_q};
                end
                default: ;
            endcase
        end
    end

    // Output byte registers are written in the DONE cycle; byte offsets wrap within the 64-byte block.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_mem <= '0;
        end else if (state == S_DONE && wren_q && !fault_q && is_out) begin
            for (int k = 0; k < 4; k++)
                if (byte_en[k])
                    out_mem[addr_q[5:0] + 6'(k)] <= st_q[8*k +: 8];
        end
    end

    assign o_io_ledr = {out_mem[3],  out_mem[2],  out_mem[1],  out_mem[0]};
    assign o_io_ledg = {out_mem[19], out_mem[18], out_mem[17], out_mem[16]};
    assign o_io_lcd  = {out_mem[51], out_mem[50], out_mem[49], out_mem[48]};

    for (genvar k = 0; k < N_HEX; k++) begin : g_hex
        assign o_io_hex[7*k +: 7] = out_mem[32+k][6:0];
    end

endmodule

// File: tb/tb_lsu_sram_mmio.sv
// Directed bench for lsu_sram_mmio: behavioural SRAM model plus a queue of expected
// load results/fault flags/latencies that is drained as each acknowledge arrives.
module tb_lsu_sram_mmio;

    localparam int DMEM_AW  = 13;
    localparam int SRAM_AW  = 18;
    localparam int WAIT_CYC = 1;
    localparam int N_HEX    = 8;
    localparam int LAT_IO   = 2;
    localparam int LAT_BH   = WAIT_CYC + 2;
    localparam int LAT_W    = 2 * WAIT_CYC + 2;

    typedef struct {
        logic [31:0] ld;
        logic        fault;
        int          lat;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               req = 1'b0;
    logic               wren = 1'b0;
    logic [2:0]         func3 = 3'b000;
    logic [31:0]        addr = '0;
    logic [31:0]        st_data = '0;
    logic [31:0]        ld_data;
    logic               ack, fault;
    logic [31:0]        io_sw = '0;
    logic [3:0]         io_btn = '0;
    logic [31:0]        ledr, ledg, lcd;
    logic [7*N_HEX-1:0] hex;
    logic [SRAM_AW-1:0] sram_addr;
    wire  [15:0]        sram_dq;
    logic               ce_n, we_n, oe_n, lb_n, ub_n;

    logic [15:0]        sram_mem [0:1023] = '{default: 16'h0000};
    logic [SRAM_AW-1:0] last_wr_addr = '0;
    logic [15:0]        last_wr_dq = '0;
    logic               last_wr_lb_n = 1'b1;
    logic               last_wr_ub_n = 1'b1;
    int                 ce_cycles = 0;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    lsu_sram_mmio #(
        .DMEM_AW(DMEM_AW), .SRAM_AW(SRAM_AW), .WAIT_CYC(WAIT_CYC), .N_HEX(N_HEX)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_wren(wren), .i_func3(func3),
        .i_addr(addr), .i_st_data(st_data), .o_ld_data(ld_data), .o_ack(ack),
        .o_fault(fault), .i_io_sw(io_sw), .i_io_btn(io_btn), .o_io_ledr(ledr),
        .o_io_ledg(ledg), .o_io_hex(hex), .o_io_lcd(lcd), .o_sram_addr(sram_addr),
        .io_sram_dq(sram_dq), .o_sram_ce_n(ce_n), .o_sram_we_n(we_n),
        .o_sram_oe_n(oe_n), .o_sram_lb_n(lb_n), .o_sram_ub_n(ub_n)
    );

    assign sram_dq = (!ce_n && !oe_n && we_n) ? sram_mem[sram_addr[9:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (!ce_n && !we_n) begin
            if (!lb_n) sram_mem[sram_addr[9:0]][7:0]  <= sram_dq[7:0];
            if (!ub_n) sram_mem[sram_addr[9:0]][15:8] <= sram_dq[15:8];
            last_wr_addr <= sram_addr;
            last_wr_dq   <= sram_dq;
            last_wr_lb_n <= lb_n;
            last_wr_ub_n <= ub_n;
        end
    end

    always @(negedge clk) if (!ce_n) ce_cycles++;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    task automatic waitAck(input string tag);
        int   n;
        bit   seen;
        exp_t e;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            if (ack === 1'b1) seen = 1'b1;
        end
        e = sb.pop_front();
        total++;
        assert (seen) else begin
            bad++;
            $error("[TB] FAIL %s_timeout: observed=no ack expected=ack within 100 clk", tag);
        end
        if (seen) begin
            checkOutput({tag, "_lat"}, 32'(n), 32'(e.lat));
            checkOutput({tag, "_ld"}, ld_data, e.ld);
            checkOutput({tag, "_fault"}, {31'h0, fault}, {31'h0, e.fault});
        end
    endtask

    task automatic applyStimulus(input string tag, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] d,
                                 input logic [31:0] exp_ld, input logic exp_fault, input int lat);
        exp_t e;
        e.ld = exp_ld;
        e.fault = exp_fault;
        e.lat = lat;
        sb.push_back(e);
        req     = 1'b1;
        wren    = wr;
        func3   = f3;
        addr    = a;
        st_data = d;
        waitAck(tag);
        req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int ce_before;
        int acks_in_reset;
        exp_t e;

        $display("[TB] start, WAIT_CYC=%0d", WAIT_CYC);
        repeat (2) @(negedge clk);
        checkOutput("rst_ack", {31'h0, ack}, 32'h0);
        checkOutput("rst_fault", {31'h0, fault}, 32'h0);
        checkOutput("rst_ld", ld_data, 32'h0);
        checkOutput("rst_ledr", ledr, 32'h0);
        checkOutput("rst_strobes", {27'h0, ce_n, we_n, oe_n, lb_n, ub_n}, 32'h1F);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus("sw_2000", 1'b1, 3'b010, 32'h2000, 32'h11223344, 32'h0, 1'b0, LAT_W);
        checkOutput("sram_hw0", {16'h0, sram_mem[0]}, 32'h3344);
        checkOutput("sram_hw1", {16'h0, sram_mem[1]}, 32'h1122);
        applyStimulus("lw_2000", 1'b0, 3'b010, 32'h2000, 32'h0, 32'h11223344, 1'b0, LAT_W);

        applyStimulus("sb_2003", 1'b1, 3'b000, 32'h2003, 32'h000000AB, 32'h0, 1'b0, LAT_BH);
        checkOutput("sb_lanes", {30'h0, last_wr_lb_n, last_wr_ub_n}, 32'h2);
        checkOutput("sb_dq", {16'h0, last_wr_dq}, 32'hAB00);
        checkOutput("sb_addr", 32'(last_wr_addr), 32'h1);
        applyStimulus("lb_2003", 1'b0, 3'b000, 32'h2003, 32'h0, 32'hFFFFFFAB, 1'b0, LAT_BH);
        applyStimulus("lbu_2003", 1'b0, 3'b100, 32'h2003, 32'h0, 32'h000000AB, 1'b0, LAT_BH);
        applyStimulus("lb_2002", 1'b0, 3'b000, 32'h2002, 32'h0, 32'h00000022, 1'b0, LAT_BH);
        applyStimulus("lh_2002", 1'b0, 3'b001, 32'h2002, 32'h0, 32'hFFFFAB22, 1'b0, LAT_BH);
        applyStimulus("lhu_2002", 1'b0, 3'b101, 32'h2002, 32'h0, 32'h0000AB22, 1'b0, LAT_BH);
        applyStimulus("lw_merge", 1'b0, 3'b010, 32'h2000, 32'h0, 32'hAB223344, 1'b0, LAT_W);

        ce_before = ce_cycles;
        applyStimulus("lh_2001", 1'b0, 3'b001, 32'h2001, 32'h0, 32'h0, 1'b1, LAT_IO);
        applyStimulus("sw_2002", 1'b1, 3'b010, 32'h2002, 32'hFFFFFFFF, 32'h0, 1'b1, LAT_IO);
        applyStimulus("size11", 1'b0, 3'b011, 32'h2000, 32'h0, 32'h0, 1'b1, LAT_IO);
        applyStimulus("func110", 1'b0, 3'b110, 32'h2000, 32'h0, 32'h0, 1'b1, LAT_IO);
        applyStimulus("sw_unmap", 1'b1, 3'b010, 32'h1000, 32'hDEADBEEF, 32'h0, 1'b0, LAT_IO);
        applyStimulus("lw_unmap", 1'b0, 3'b010, 32'h1000, 32'h0, 32'h0, 1'b0, LAT_IO);
        checkOutput("no_sram_cycles", 32'(ce_cycles - ce_before), 32'h0);
        applyStimulus("lw_after_fault", 1'b0, 3'b010, 32'h2000, 32'h0, 32'hAB223344, 1'b0, LAT_W);

        applyStimulus("sw_hex", 1'b1, 3'b010, 32'h7020, 32'h00000079, 32'h0, 1'b0, LAT_IO);
        checkOutput("hex0", {25'h0, hex[6:0]}, 32'h79);
        checkOutput("hex1", {25'h0, hex[13:7]}, 32'h0);
        applyStimulus("lw_7010", 1'b0, 3'b010, 32'h7010, 32'h0, 32'h0, 1'b0, LAT_IO);
        applyStimulus("lw_7020", 1'b0, 3'b010, 32'h7020, 32'h0, 32'h79, 1'b0, LAT_IO);
        applyStimulus("sh_ledr", 1'b1, 3'b001, 32'h7002, 32'h1234BEEF, 32'h0, 1'b0, LAT_IO);
        checkOutput("ledr", ledr, 32'hBEEF0000);
        applyStimulus("lh_ledr", 1'b0, 3'b001, 32'h7002, 32'h0, 32'hFFFFBEEF, 1'b0, LAT_IO);
        applyStimulus("sb_ledg", 1'b1, 3'b000, 32'h7011, 32'hFFFFFF5A, 32'h0, 1'b0, LAT_IO);
        checkOutput("ledg", ledg, 32'h00005A00);
        applyStimulus("sw_lcd", 1'b1, 3'b010, 32'h7030, 32'hCAFEF00D, 32'h0, 1'b0, LAT_IO);
        checkOutput("lcd", lcd, 32'hCAFEF00D);

        io_sw  = 32'h000000A5;
        io_btn = 4'hB;
        repeat (3) @(negedge clk);
        applyStimulus("lw_sw", 1'b0, 3'b010, 32'h7800, 32'h0, 32'h000000A5, 1'b0, LAT_IO);
        applyStimulus("lb_sw", 1'b0, 3'b000, 32'h7800, 32'h0, 32'hFFFFFFA5, 1'b0, LAT_IO);
        applyStimulus("lbu_btn", 1'b0, 3'b100, 32'h7810, 32'h0, 32'h0000000B, 1'b0, LAT_IO);
        applyStimulus("lw_in_empty", 1'b0, 3'b010, 32'h7804, 32'h0, 32'h0, 1'b0, LAT_IO);

        // Request held high across two accesses: the second ack trails the first by one access plus the idle cycle.
        e.ld = 32'hAB223344; e.fault = 1'b0; e.lat = LAT_W;
        sb.push_back(e);
        e.lat = LAT_W + 1;
        sb.push_back(e);
        req = 1'b1; wren = 1'b0; func3 = 3'b010; addr = 32'h2000;
        waitAck("b2b_first");
        waitAck("b2b_second");
        req = 1'b0;
        @(negedge clk);

        req = 1'b1; wren = 1'b0; func3 = 3'b010; addr = 32'h2000;
        repeat (2 + WAIT_CYC) @(negedge clk);
        checkOutput("mid_hi_active", {31'h0, ce_n}, 32'h0);
        checkOutput("mid_hi_addr", 32'(sram_addr), 32'h1);
        rst_n = 1'b0;
        req   = 1'b0;
        #1;
        checkOutput("rst_mid_strobes", {27'h0, ce_n, we_n, oe_n, lb_n, ub_n}, 32'h1F);
        checkOutput("rst_mid_ack", {31'h0, ack}, 32'h0);
        acks_in_reset = 0;
        repeat (3) begin
            @(negedge clk);
            if (ack === 1'b1) acks_in_reset++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        if (ack === 1'b1) acks_in_reset++;
        checkOutput("rst_mid_no_ack", 32'(acks_in_reset), 32'h0);
        checkOutput("rst_mid_ledr", ledr, 32'h0);
        applyStimulus("lw_after_rst", 1'b0, 3'b010, 32'h2000, 32'h0, 32'hAB223344, 1'b0, LAT_W);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
